pipe_reg_chain: RTL

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/aww_types_pkg.sv | 22 ++
 rtl/pipe_stage.sv | 31 +++
 rtl/pipe_reg_chain.sv | 88 ++++++++
 3 files changed

// File: rtl/aww_types_pkg.sv
// Shared types for the register-chain pipeline: per-stage control and counter ops.
package aww_types_pkg;

    typedef struct packed {
        logic hold;
        logic flush;
    } stage_ctrl_t;

    typedef enum logic [1:0] {
        CNT_KEEP = 2'd0,
        CNT_INC  = 2'd1,
        CNT_CLR  = 2'd2
    } cnt_op_t;

    // Clear beats increment so software can zero a counter under any traffic.
    function automatic cnt_op_t cnt_op(input logic clr, input logic inc);
        if (clr)      return CNT_CLR;
        else if (inc) return CNT_INC;
        else          return CNT_KEEP;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid + payload register with flush, hold and capture.
module pipe_stage
    import aww_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  stage_ctrl_t      ctrl,
    input  logic             cap,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    // Flush outranks capture: anything arriving this cycle is dropped.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (ctrl.flush) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (cap && !ctrl.hold) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain with per-stage hold/flush, bubble collapse and perf counters.
module pipe_reg_chain
    import aww_types_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int WIDTH  = 32,
    parameter int CNTW   = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     freeze,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic [NSTAGE-1:0]        stage_hold,
    input  logic [NSTAGE-1:0]        stage_flush,
    input  logic                     out_ready,
    output logic [NSTAGE-1:0]        stg_valid,
    output logic [NSTAGE*WIDTH-1:0]  stg_data,
    output logic                     out_valid,
    input  logic                     cnt_clr,
    output logic [CNTW-1:0]          bubble_cnt,
    output logic [CNTW-1:0]          stall_cnt
);

    logic [NSTAGE-1:0]             accept, move;
    logic [NSTAGE-1:0]             up_valid;
    logic [NSTAGE-1:0][WIDTH-1:0]  up_data, stg_q;

    // Ready ripples combinationally from the output back to stage 0.
    always_comb begin
        accept = '0;
        move   = '0;
        move[NSTAGE-1]   = stg_valid[NSTAGE-1] & out_ready & ~stage_hold[NSTAGE-1];
        accept[NSTAGE-1] = ~freeze & ~stage_hold[NSTAGE-1] & (~stg_valid[NSTAGE-1] | move[NSTAGE-1]);
        for (int i = NSTAGE-2; i >= 0; i--) begin
            move[i]   = stg_valid[i] & accept[i+1];
            accept[i] = ~freeze & ~stage_hold[i] & (~stg_valid[i] | move[i]);
        end
    end

    assign in_ready  = accept[0];
    assign out_valid = stg_valid[NSTAGE-1];
    assign up_valid  = {stg_valid[NSTAGE-2:0], in_valid};
    assign up_data   = {stg_q[NSTAGE-2:0], in_data};
    assign stg_data  = stg_q;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        stage_ctrl_t ctrl;
        assign ctrl.hold  = stage_hold[g] | freeze;
        assign ctrl.flush = stage_flush[g] & ~freeze;

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK     (CLK),
            .nRST    (nRST),
            .ctrl    (ctrl),
            .cap     (accept[g]),
            .d_valid (up_valid[g]),
            .d_data  (up_data[g]),
            .q_valid (stg_valid[g]),
            .q_data  (stg_q[g])
        );
    end

    cnt_op_t bubble_op, stall_op;
    assign bubble_op = cnt_op(cnt_clr, ~freeze & ~out_valid);
    assign stall_op  = cnt_op(cnt_clr, ~freeze & out_valid &
                                       (~out_ready | stage_hold[NSTAGE-1]));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            case (bubble_op)
                CNT_CLR: bubble_cnt <= '0;
                CNT_INC: if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNTW'(1);
                default: ;
            endcase
            case (stall_op)
                CNT_CLR: stall_cnt <= '0;
                CNT_INC: if (stall_cnt != '1) stall_cnt <= stall_cnt + CNTW'(1);
                default: ;
            endcase
        end
    end

endmodule
